// File: rtl/rbz_spi_reg_host.sv
// SPI mode-0 write-frame host for the rbzero register/POV port: one right-aligned,
// MSB-first frame per request. Optional abort input/pulse under RBZ_SPI_HOST_ABORT_EN.
//
//   state    | meaning
//   ---------+--------------------------------------------------
//   IDLE     | ss_n high, waiting for i_start
//   SHIFT_LO | sclk low, current bit driven on mosi
//   SHIFT_HI | sclk high, bit held, shift on exit
//   HOLD     | all bits sent, ss_n still low, sclk/mosi low
//   GAP      | ss_n high for one half-period before done
module rbz_spi_reg_host #(
    parameter int CLK_DIV  = 2,
    parameter int MAX_BITS = 80
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_start,
    input  logic [6:0]          i_len,
    input  logic [MAX_BITS-1:0] i_data,
`ifdef RBZ_SPI_HOST_ABORT_EN
    input  logic                i_abort,
    output logic                o_aborted,
`endif
    output logic                o_busy,
    output logic                o_done,
    output logic                o_sclk,
    output logic                o_mosi,
    output logic                o_ss_n
);

    localparam int LW = 8;
    localparam logic [LW-1:0] DIV_LAST = LW'(CLK_DIV - 1);
    localparam logic [LW-1:0] MAX_LEN  = LW'(MAX_BITS);

    typedef enum logic [2:0] {
        IDLE,
        SHIFT_LO,
        SHIFT_HI,
        HOLD,
        GAP
    } state_t;

    state_t              state, state_nxt;
    logic [LW-1:0]       div_cnt, div_nxt;
    logic [LW-1:0]       bits_left, bits_nxt;
    logic [MAX_BITS-1:0] shreg, shreg_nxt;
    logic                done_nxt;
    logic                ss_n_nxt, sclk_nxt, mosi_nxt, busy_nxt;
    logic                div_end;
    logic [LW-1:0]       len_req, len_eff;
    logic [MAX_BITS-1:0] shreg_load;
`ifdef RBZ_SPI_HOST_ABORT_EN
    logic                aborted_nxt;
`endif

    assign len_req    = {1'b0, i_len};
    assign len_eff    = (len_req > MAX_LEN) ? MAX_LEN : len_req;
    // Left-justify the payload so the first bit to send sits at the MSB.
    assign shreg_load = i_data << (MAX_LEN - len_eff);
    assign div_end    = (div_cnt == DIV_LAST);

    always_comb begin
        state_nxt = state;
        div_nxt   = div_cnt;
        bits_nxt  = bits_left;
        shreg_nxt = shreg;
        done_nxt  = 1'b0;
`ifdef RBZ_SPI_HOST_ABORT_EN
        aborted_nxt = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (i_start) begin
                    if (len_eff == '0) begin
                        done_nxt = 1'b1;
                    end else begin
                        shreg_nxt = shreg_load;
                        bits_nxt  = len_eff;
                        div_nxt   = '0;
                        state_nxt = SHIFT_LO;
                    end
                end
            end
            SHIFT_LO: begin
                if (div_end) begin
                    div_nxt   = '0;
                    state_nxt = SHIFT_HI;
                end else begin
                    div_nxt = div_cnt + 1'b1;
                end
            end
            SHIFT_HI: begin
                if (div_end) begin
                    div_nxt   = '0;
                    shreg_nxt = {shreg[MAX_BITS-2:0], 1'b0};
                    bits_nxt  = bits_left - 1'b1;
                    state_nxt = (bits_left == LW'(1)) ? HOLD : SHIFT_LO;
                end else begin
                    div_nxt = div_cnt + 1'b1;
                end
            end
            HOLD: begin
                if (div_end) begin
                    div_nxt   = '0;
                    state_nxt = GAP;
                end else begin
                    div_nxt = div_cnt + 1'b1;
                end
            end
            GAP: begin
                if (div_end) begin
                    div_nxt   = '0;
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    div_nxt = div_cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
`ifdef RBZ_SPI_HOST_ABORT_EN
        // Abort skips HOLD/GAP entirely and suppresses done.
        if (i_abort && (state != IDLE)) begin
            state_nxt   = IDLE;
            div_nxt     = '0;
            done_nxt    = 1'b0;
            aborted_nxt = 1'b1;
        end
`endif
    end

    // Outputs are registered from the next state so they line up with it.
    always_comb begin
        ss_n_nxt = !((state_nxt == SHIFT_LO) || (state_nxt == SHIFT_HI) || (state_nxt == HOLD));
        sclk_nxt = (state_nxt == SHIFT_HI);
        mosi_nxt = ((state_nxt == SHIFT_LO) || (state_nxt == SHIFT_HI)) ? shreg_nxt[MAX_BITS-1] : 1'b0;
        busy_nxt = (state_nxt != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            div_cnt   <= '0;
            bits_left <= '0;
            shreg     <= '0;
            o_ss_n    <= 1'b1;
            o_sclk    <= 1'b0;
            o_mosi    <= 1'b0;
            o_busy    <= 1'b0;
            o_done    <= 1'b0;
        end else begin
            state     <= state_nxt;
            div_cnt   <= div_nxt;
            bits_left <= bits_nxt;
            shreg     <= shreg_nxt;
            o_ss_n    <= ss_n_nxt;
            o_sclk    <= sclk_nxt;
            o_mosi    <= mosi_nxt;
            o_busy    <= busy_nxt;
            o_done    <= done_nxt;
        end
    end

`ifdef RBZ_SPI_HOST_ABORT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_aborted <= 1'b0;
        end else begin
            o_aborted <= aborted_nxt;
        end
    end
`endif

endmodule

// File: doc/rbz_spi_reg_host.md
# rbz_spi_reg_host

SPI controller that drives the register/POV SPI peripheral of `rbzero`, i.e. the `i_reg_sclk` / `i_reg_mosi` / `i_reg_ss_n` inputs. It serialises one right-aligned, variable-length write frame per request, MSB first, in SPI mode 0. It is used in the test harness and in companion host-side designs to update POV vectors and registers without an external MCU.

## Interface
Parameters:
- `CLK_DIV`, default 2: SCLK half-period in `clk` cycles. Legal range is 1..255.
- `MAX_BITS`, default 80: width of `i_data` and the maximum frame length.

Ports:
- `clk` in 1: sole clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `i_start` in 1: request a frame. Sampled only in IDLE.
- `i_len` in 7: frame length in bits.
- `i_data` in MAX_BITS: payload, right-aligned. The first bit sent is `i_data[i_len-1]`.
- `o_busy` out 1: high while a frame is in progress.
- `o_done` out 1: one-cycle pulse when a frame completes.
- `o_sclk` out 1: SPI clock. Idles low.
- `o_mosi` out 1: SPI data.
- `o_ss_n` out 1: chip select, active-low.

## Operation
- States: IDLE, SHIFT_LO, SHIFT_HI, HOLD, GAP.
  - A half-period counter `div_cnt` counts 0..CLK_DIV-1.
  - A bit counter `bits_left` holds the remaining bits.
- **IDLE**
  - Outputs: `o_ss_n`=1, `o_sclk`=0, `o_busy`=0.
  - On `i_start`=1 with an effective length N≥1:
    - Latch `i_data` into a shift register, left-justified by N.
    - Load `bits_left`=N.
    - Go to SHIFT_LO.
- **Length rules**
  - N = min(`i_len`, MAX_BITS).
  - `i_len`=0: no SPI activity. `o_done` pulses the next cycle and `o_busy` stays 0.
- **SHIFT_LO**
  - `o_ss_n`=0, `o_sclk`=0, `o_mosi` = current MSB.
  - After CLK_DIV cycles go to SHIFT_HI.
- **SHIFT_HI**
  - `o_sclk`=1 and `o_mosi` is held.
  - After CLK_DIV cycles, shift left and decrement `bits_left`.
  - If `bits_left` was 1, go to HOLD; otherwise go to SHIFT_LO.
- **HOLD**
  - `o_sclk`=0, `o_ss_n`=0, `o_mosi`=0.
  - After CLK_DIV cycles go to GAP.
- **GAP**
  - `o_ss_n`=1.
  - After CLK_DIV cycles go to IDLE and pulse `o_done`.
- `i_start` is ignored while busy. It is not queued.
- `i_data` and `i_len` may change freely after the start cycle.
- `o_mosi` is 0 whenever `o_ss_n`=1.

## Timing
- All outputs are registered. Reset values:
  - `o_ss_n`=1, `o_sclk`=0, `o_mosi`=0.
  - `o_busy`=0, `o_done`=0.
  - State = IDLE.
- Reset asserted mid-frame returns all outputs to their reset values immediately (asynchronous). The frame is lost and `o_done` does not pulse.
- Cycle numbering: the start is sampled at the clock edge ending cycle 0, and D = CLK_DIV.
- Frame timing:
  - Cycle 1: `o_ss_n` falls, `o_busy` rises, and the first bit is on `o_mosi`.
  - Rising SCLK edge k (k=0..N-1) appears at cycle 1 + D + 2kD.
  - `o_mosi` is stable for D cycles before and D cycles after each rising edge.
  - `o_ss_n` is low for 2ND + D cycles.
  - GAP lasts D cycles.
  - `o_busy` is high for cycles 1 .. 2ND+2D.
  - `o_done` is high in cycle 2ND+2D+1, in which `o_busy` is already 0.
- Back-to-back frames:
  - The earliest next start is in the `o_done` cycle.
  - The minimum `o_ss_n` high time between frames is D+1 cycles.

## Configuration
- `RBZ_SPI_HOST_ABORT_EN`
  - **Defined:** adds input `i_abort` and output `o_aborted`.
    - `i_abort`=1 in any non-IDLE state forces HOLD-free termination.
    - Next cycle: `o_sclk`=0, `o_ss_n`=1, `o_mosi`=0, `o_busy`=0.
    - `o_aborted` pulses for one cycle and `o_done` does not pulse.
    - `i_abort` in IDLE is ignored.
    - If `i_start` and `i_abort` arrive in the same IDLE cycle, the start wins.
  - **Undefined:** both ports are absent and frames always run to completion.

## Test plan
- **Single frame:** CLK_DIV=2, `i_len`=8, `i_data`=0xA5, pulse start at cycle 0.
  - MOSI sampled at the 8 SCLK rises gives 1,0,1,0,0,1,0,1.
  - `o_ss_n` is low for cycles 1–34.
  - `o_busy` is high for cycles 1–36.
  - `o_done` is high at cycle 37 only.
- **Full-width frame:** CLK_DIV=1, `i_len`=74, random 74-bit payload.
  - A reference SPI-mode-0 sampler recovers the payload exactly.
  - There are exactly 74 rising edges.
- **Length edge cases:**
  - `i_len`=0 produces an `o_done` pulse at cycle 1 with `o_ss_n` staying 1.
  - `i_len`=100 with MAX_BITS=80 sends 80 bits, starting from `i_data[79]`.
- **Start while busy:** pulse start again mid-frame with different data.
  - Only the first frame is sent.
  - Starting in the `o_done` cycle launches the second frame with ≥2 cycles of `o_ss_n` high.
- **Reset mid-frame:** assert `rst_n`=0 during bit 3.
  - Outputs immediately go to `o_ss_n`=1, `o_sclk`=0, `o_busy`=0.
  - No `o_done` pulse.
  - After release, a new frame runs normally.
- **Abort (`RBZ_SPI_HOST_ABORT_EN` defined):** assert `i_abort` at cycle 10, with CLK_DIV=2 and `i_len`=8.
  - `o_ss_n`=1 and `o_aborted`=1 at cycle 11.
  - No `o_done` pulse.
  - No SCLK edges after cycle 10.
